// File: rtl/jtcontra_cab_inputs.sv
// -----------------------------------------------------------------------------
// jtcontra_cab_inputs
//
// Conditions the cabinet inputs of the Contra core before the main CPU sees
// them. Every raw bit is synchronised, debounced and presented as a clean
// active-low level. The coin switches are turned into frame-timed pulses, and
// holding both start buttons produces a service request.
//
// Optional feature: define JTCONTRA_AUTOFIRE_EN to build autofire on bit 4
// (button 1) of both joysticks. Leave it undefined for plain pass-through.
//
// Parameters
//   DEBOUNCE       consecutive equal samples needed to accept a new level (2..15)
//   COIN_FRAMES    minimum coin pulse width in frames (1..7)
//
// Ports
//   clk            24 MHz clock shared with the main CPU
//   rstn           asynchronous active-low reset
//   cen_smp        one-clk sampling strobe that advances the debouncers
//   LVBL           vertical blank, active low; its falling edge is a frame tick
//   start_raw      raw start buttons, active low
//   coin_raw       raw coin switches, active low
//   joy1_raw       raw joystick 1, active low, bit 4 = button 1
//   joy2_raw       raw joystick 2, active low, bit 4 = button 1
//   start_button   conditioned starts, active low
//   coin_input     conditioned coin pulses, active low
//   joystick1      conditioned joystick 1, active low
//   joystick2      conditioned joystick 2, active low
//   service        service request, active low
//   coin_state_dbg coin FSM states, {channel 1, channel 0}
//                  (0 = IDLE, 1 = PULSE, 2 = WAITREL)
// -----------------------------------------------------------------------------
module jtcontra_cab_inputs #(
  parameter int DEBOUNCE    = 4,
  parameter int COIN_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cen_smp,
  input  logic       LVBL,
  input  logic [1:0] start_raw,
  input  logic [1:0] coin_raw,
  input  logic [5:0] joy1_raw,
  input  logic [5:0] joy2_raw,
  output logic [1:0] start_button,
  output logic [1:0] coin_input,
  output logic [5:0] joystick1,
  output logic [5:0] joystick2,
  output logic       service,
  output logic [3:0] coin_state_dbg
);

  // Bit map of the conditioned bundle:
  //   [1:0] start, [3:2] coin, [9:4] joystick 1, [15:10] joystick 2
  localparam int NB = 16;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_PULSE   = 2'd1,
    C_WAITREL = 2'd2
  } coin_st_e;

  logic [NB-1:0] raw_w;
  assign raw_w = {joy2_raw, joy1_raw, coin_raw, start_raw};

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on every raw bit
  // ---------------------------------------------------------------------------
  logic [NB-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame tick: one clk wide, on the falling edge of LVBL
  // ---------------------------------------------------------------------------
  logic lvbl_q;
  logic frame_tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lvbl_q <= 1'b1;
    else       lvbl_q <= LVBL;
  end

  assign frame_tick = lvbl_q & ~LVBL;

  // ---------------------------------------------------------------------------
  // Debouncers. The counter holds how many differing samples have been seen
  // so far; the level flips on the sample that would take it past
  // DEBOUNCE-1, so exactly DEBOUNCE differing samples are needed.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] acc_q, acc_d;
  logic [3:0]    deb_cnt_q [NB];
  logic [3:0]    deb_cnt_d [NB];

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (cen_smp) begin
        if (sync2_q[i] == acc_q[i]) begin
          deb_cnt_d[i] = 4'd0;
        end else if (deb_cnt_q[i] == 4'(DEBOUNCE - 1)) begin
          acc_d[i]     = ~acc_q[i];
          deb_cnt_d[i] = 4'd0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '1;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= 4'd0;
    end else begin
      acc_q <= acc_d;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Button 1 of each joystick: autofire or plain pass-through
  // ---------------------------------------------------------------------------
  logic [1:0] fire_d;
  logic [5:0] joy1_q, joy2_q;
  logic [1:0] start_q;

`ifdef JTCONTRA_AUTOFIRE_EN
  // af_act marks a press already in progress, so the first cycle of a press
  // forces the output low and later cycles toggle it every fourth frame.
  logic [1:0] af_act_q, af_act_d;
  logic [1:0] af_cnt_q [2];
  logic [1:0] af_cnt_d [2];
  logic [1:0] af_acc, af_cur;

  assign af_acc = {acc_q[14], acc_q[8]};
  assign af_cur = {joy2_q[4], joy1_q[4]};

  always_comb begin
    af_act_d = af_act_q;
    fire_d   = af_cur;
    for (int n = 0; n < 2; n++) begin
      af_cnt_d[n] = af_cnt_q[n];
      if (af_acc[n]) begin
        af_act_d[n] = 1'b0;
        af_cnt_d[n] = 2'd0;
        fire_d[n]   = 1'b1;
      end else if (!af_act_q[n]) begin
        af_act_d[n] = 1'b1;
        af_cnt_d[n] = 2'd0;
        fire_d[n]   = 1'b0;
      end else if (frame_tick) begin
        if (af_cnt_q[n] == 2'd3) begin
          af_cnt_d[n] = 2'd0;
          fire_d[n]   = ~af_cur[n];
        end else begin
          af_cnt_d[n] = af_cnt_q[n] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      af_act_q <= 2'b00;
      for (int n = 0; n < 2; n++) af_cnt_q[n] <= 2'd0;
    end else begin
      af_act_q <= af_act_d;
      for (int n = 0; n < 2; n++) af_cnt_q[n] <= af_cnt_d[n];
    end
  end
`else
  assign fire_d = {acc_q[14], acc_q[8]};
`endif

  // ---------------------------------------------------------------------------
  // Registered start / joystick outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q <= 2'b11;
      joy1_q  <= 6'h3f;
      joy2_q  <= 6'h3f;
    end else begin
      start_q <= acc_q[1:0];
      joy1_q  <= {acc_q[9],  fire_d[0], acc_q[7:4]};
      joy2_q  <= {acc_q[15], fire_d[1], acc_q[13:10]};
    end
  end

  assign start_button = start_q;
  assign joystick1    = joy1_q;
  assign joystick2    = joy2_q;

  // ---------------------------------------------------------------------------
  // Coin channels. A falling edge of the accepted level launches a pulse that
  // lasts COIN_FRAMES frame ticks; the channel then waits for the switch to
  // be released before it can fire again, so a held coin gives one pulse.
  // ---------------------------------------------------------------------------
  logic [1:0] coin_prev_q;
  logic [1:0] coin_fall;
  coin_st_e   coin_st_q [2];
  coin_st_e   coin_st_d [2];
  logic [2:0] fcnt_q [2];
  logic [2:0] fcnt_d [2];

  assign coin_fall = coin_prev_q & ~acc_q[3:2];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      coin_st_d[n] = coin_st_q[n];
      fcnt_d[n]    = fcnt_q[n];
      case (coin_st_q[n])
        C_IDLE: begin
          if (coin_fall[n]) begin
            coin_st_d[n] = C_PULSE;
            fcnt_d[n]    = 3'd0;
          end
        end
        C_PULSE: begin
          if (frame_tick) begin
            if (fcnt_q[n] == 3'(COIN_FRAMES - 1)) begin
              coin_st_d[n] = C_WAITREL;
              fcnt_d[n]    = 3'd0;
            end else begin
              fcnt_d[n] = fcnt_q[n] + 3'd1;
            end
          end
        end
        C_WAITREL: begin
          if (acc_q[2 + n]) coin_st_d[n] = C_IDLE;
        end
        default: begin
          coin_st_d[n] = C_IDLE;
          fcnt_d[n]    = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coin_prev_q <= 2'b11;
      for (int n = 0; n < 2; n++) begin
        coin_st_q[n] <= C_IDLE;
        fcnt_q[n]    <= 3'd0;
      end
    end else begin
      coin_prev_q <= acc_q[3:2];
      for (int n = 0; n < 2; n++) begin
        coin_st_q[n] <= coin_st_d[n];
        fcnt_q[n]    <= fcnt_d[n];
      end
    end
  end

  // Driven straight from the state flops so reset releases the pulse at once.
  always_comb begin
    for (int n = 0; n < 2; n++) coin_input[n] = (coin_st_q[n] != C_PULSE);
  end

  assign coin_state_dbg = {coin_st_q[1], coin_st_q[0]};

  // ---------------------------------------------------------------------------
  // Service request: both starts held for 64 frame ticks. The hold counter
  // saturates at 63; the 64th qualifying tick asserts service.
  // ---------------------------------------------------------------------------
  logic [5:0] hold_q, hold_d;
  logic       service_q, service_d;

  always_comb begin
    hold_d    = hold_q;
    service_d = service_q;
    if (frame_tick) begin
      if (acc_q[1:0] == 2'b00) begin
        if (hold_q == 6'd63) service_d = 1'b0;
        else                 hold_d    = hold_q + 6'd1;
      end else begin
        hold_d    = 6'd0;
        service_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q    <= 6'd0;
      service_q <= 1'b1;
    end else begin
      hold_q    <= hold_d;
      service_q <= service_d;
    end
  end

  assign service = service_q;

endmodule

// File: tb/tb_jtcontra_cab_inputs.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_cab_inputs
//
// Directed bench for jtcontra_cab_inputs. Inputs are driven 1 ns after the
// rising clk edge and outputs are sampled at the same phase. A sample step is
// one cen_smp pulse followed by one idle clk; a frame step is one LVBL fall.
// -----------------------------------------------------------------------------
module tb_jtcontra_cab_inputs;

  localparam int DEB = 4;
  localparam int CF  = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rstn;
  logic       cen_smp;
  logic       LVBL;
  logic [1:0] start_raw;
  logic [1:0] coin_raw;
  logic [5:0] joy1_raw;
  logic [5:0] joy2_raw;
  logic [1:0] start_button;
  logic [1:0] coin_input;
  logic [5:0] joystick1;
  logic [5:0] joystick2;
  logic       service;
  logic [3:0] coin_state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jtcontra_cab_inputs #(
    .DEBOUNCE    (DEB),
    .COIN_FRAMES (CF)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cen_smp        (cen_smp),
    .LVBL           (LVBL),
    .start_raw      (start_raw),
    .coin_raw       (coin_raw),
    .joy1_raw       (joy1_raw),
    .joy2_raw       (joy2_raw),
    .start_button   (start_button),
    .coin_input     (coin_input),
    .joystick1      (joystick1),
    .joystick2      (joystick2),
    .service        (service),
    .coin_state_dbg (coin_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Lets a raw change reach the synchroniser output.
  task automatic settle();
    step_clk(2);
  endtask

  task automatic sample(input int n);
    for (int i = 0; i < n; i++) begin
      cen_smp = 1'b1;
      step_clk(1);
      cen_smp = 1'b0;
      step_clk(1);
    end
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      LVBL = 1'b0;
      step_clk(1);
      LVBL = 1'b1;
      step_clk(3);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int   pulse_frames;
  logic other_low;

  initial begin
    rstn      = 1'b0;
    cen_smp   = 1'b0;
    LVBL      = 1'b1;
    start_raw = 2'b11;
    coin_raw  = 2'b11;
    joy1_raw  = 6'h3f;
    joy2_raw  = 6'h3f;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_start",   32'(start_button), 32'h3);
    check("rst_coin",    32'(coin_input),   32'h3);
    check("rst_joy1",    32'(joystick1),    32'h3f);
    check("rst_joy2",    32'(joystick2),    32'h3f);
    check("rst_service", 32'(service),      32'h1);
    check("rst_coin_st", 32'(coin_state_dbg), 32'h0);
    rstn = 1'b1;
    step_clk(2);

    // Glitch of DEBOUNCE-1 samples on coin 0 is rejected
    coin_raw[0] = 1'b0;
    settle();
    sample(3);
    coin_raw[0] = 1'b1;
    settle();
    sample(DEB);
    check("glitch_coin",    32'(coin_input),     32'h3);
    check("glitch_coin_st", 32'(coin_state_dbg), 32'h0);
    frame(CF + 1);
    check("glitch_no_pulse", 32'(coin_input), 32'h3);

    // Debounce latency on joy1[2]: press then release
    joy1_raw[2] = 1'b0;
    settle();
    for (int i = 0; i < DEB - 1; i++) exp_q.push_back(32'h1);
    while (exp_q.size() > 0) begin
      sample(1);
      check("deb_press_hold", 32'(joystick1[2]), exp_q.pop_front());
    end
    cen_smp = 1'b1;
    step_clk(1);
    cen_smp = 1'b0;
    check("deb_press_edge", 32'(joystick1[2]), 32'h1);
    step_clk(1);
    check("deb_press_out", 32'(joystick1), 32'h3b);

    joy1_raw[2] = 1'b1;
    settle();
    for (int i = 0; i < DEB - 1; i++) exp_q.push_back(32'h0);
    while (exp_q.size() > 0) begin
      sample(1);
      check("deb_rel_hold", 32'(joystick1[2]), exp_q.pop_front());
    end
    cen_smp = 1'b1;
    step_clk(1);
    cen_smp = 1'b0;
    check("deb_rel_edge", 32'(joystick1[2]), 32'h0);
    step_clk(1);
    check("deb_rel_out", 32'(joystick1), 32'h3f);

    // Joystick pass-through patterns (button 1 kept released)
    joy1_raw = 6'b011010;
    joy2_raw = 6'b110101;
    settle();
    sample(DEB);
    check("pat_joy1", 32'(joystick1), 32'h1a);
    check("pat_joy2", 32'(joystick2), 32'h35);
    joy1_raw = 6'h3f;
    joy2_raw = 6'h3f;
    settle();
    sample(DEB);
    check("pat_joy_rel", 32'({joystick2, joystick1}), 32'hfff);

    // Coin 1 held for 10 frames: one pulse of CF ticks
    coin_raw[1] = 1'b0;
    settle();
    sample(DEB);
    check("coin1_start", 32'(coin_input), 32'h1);
    pulse_frames = 0;
    other_low    = 1'b0;
    for (int f = 0; f < 10; f++) begin
      if (coin_input[1] == 1'b0) pulse_frames++;
      if (coin_input[0] == 1'b0) other_low = 1'b1;
      frame(1);
    end
    check("coin1_width",   32'(pulse_frames),   32'(CF));
    check("coin1_waitrel", 32'(coin_state_dbg), 32'h8);
    coin_raw[1] = 1'b1;
    settle();
    sample(DEB);
    check("coin1_idle", 32'(coin_state_dbg), 32'h0);

    // Second press gives a second pulse
    coin_raw[1] = 1'b0;
    settle();
    sample(DEB);
    pulse_frames = 0;
    for (int f = 0; f < 6; f++) begin
      if (coin_input[1] == 1'b0) pulse_frames++;
      if (coin_input[0] == 1'b0) other_low = 1'b1;
      frame(1);
    end
    check("coin1_width2", 32'(pulse_frames), 32'(CF));
    check("coin0_quiet",  32'(other_low),    32'h0);
    coin_raw[1] = 1'b1;
    settle();
    sample(DEB);

    // Simultaneous coins
    coin_raw = 2'b00;
    settle();
    sample(DEB);
    check("coin_both_on", 32'(coin_input), 32'h0);
    frame(CF);
    check("coin_both_off", 32'(coin_input), 32'h3);
    coin_raw = 2'b11;
    settle();
    sample(DEB);

    // Service: both starts held for 64 frames
    start_raw = 2'b00;
    settle();
    sample(DEB);
    check("svc_starts", 32'(start_button), 32'h0);
    frame(63);
    check("svc_63", 32'(service), 32'h1);
    frame(1);
    check("svc_64", 32'(service), 32'h0);
    frame(70);
    check("svc_sat", 32'(service), 32'h0);
    start_raw[0] = 1'b1;
    settle();
    sample(DEB);
    check("svc_wait_tick", 32'(service), 32'h0);
    frame(1);
    check("svc_release", 32'(service), 32'h1);
    start_raw = 2'b00;
    settle();
    sample(DEB);
    frame(63);
    check("svc_rehold_63", 32'(service), 32'h1);
    frame(1);
    check("svc_rehold_64", 32'(service), 32'h0);
    start_raw = 2'b11;
    settle();
    sample(DEB);
    frame(1);
    check("svc_off", 32'(service), 32'h1);

    // Reset during a coin pulse
    coin_raw[0] = 1'b0;
    settle();
    sample(DEB);
    check("rst_mid_pulse", 32'(coin_input), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async_coin",  32'(coin_input),     32'h3);
    check("rst_async_st",    32'(coin_state_dbg), 32'h0);
    check("rst_async_outs",  32'({service, start_button, joystick2, joystick1}), 32'h7fff);
    step_clk(2);
    rstn = 1'b1;
    settle();
    sample(DEB - 1);
    check("rst_no_pulse", 32'(coin_input), 32'h3);
    sample(1);
    check("rst_fresh_pulse", 32'(coin_input), 32'h2);
    frame(CF);
    check("rst_pulse_end", 32'(coin_input), 32'h3);
    coin_raw[0] = 1'b1;
    settle();
    sample(DEB);

    // Button 1 of joystick 2
    joy2_raw[4] = 1'b0;
    settle();
    sample(DEB);
    check("b1_press", 32'(joystick2), 32'h2f);
`ifdef JTCONTRA_AUTOFIRE_EN
    frame(4);
    check("af_step1", 32'(joystick2[4]), 32'h1);
    frame(4);
    check("af_step2", 32'(joystick2[4]), 32'h0);
    frame(4);
    check("af_step3", 32'(joystick2[4]), 32'h1);
    frame(4);
`else
    frame(16);
    check("b1_held", 32'(joystick2), 32'h2f);
`endif
    joy2_raw[4] = 1'b1;
    settle();
    sample(DEB);
    check("b1_release", 32'(joystick2), 32'h3f);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
